dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters:
  - the pipeline MEM stage (port P);
  - the syscall handler (port S), which reads and writes memory for print/read syscalls.
- Converts fixed-latency memory accesses into a stall signal toward the hazard unit and a req/ack handshake toward the syscall handler.
- Sits between the memory stage and the data memory instance; replaces the direct connection between them.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en cycle to mem_rdata valid (legal range >= 1).
- STARVE_MAX, 4, consecutive P grants while s_req pending before S is forced through (legal range >= 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p_req  in  1  MEM-stage access request (MemWriteM | MemToRegM).
- p_we  in  1  1 = write (MemWriteM).
- p_addr  in  ADDR_W  address (ALUOutM).
- p_wdata  in  DATA_W  store data (forwarded WriteDataM).
- p_rdata  out  DATA_W  load data to writeback; valid while p_stall = 0 after a P read.
- p_stall  out  1  stall request to hazard unit (combinational).
- s_req  in  1  syscall handler request; held until s_ack.
- s_we  in  1  syscall write.
- s_addr  in  ADDR_W  syscall address.
- s_wdata  in  DATA_W  syscall store data.
- s_ack  out  1  one-cycle completion pulse.
- s_rdata  out  DATA_W  syscall read data; valid from s_ack cycle until next S completion.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:

Reset (asynchronous):
- state = IDLE, owner = P, cnt = 0, starve_cnt = 0.
- mem_en = 0, mem_we = 0; mem_addr, mem_wdata, p_rdata, s_rdata = 0; s_ack = 0.

States: IDLE, WAIT, DONE.

IDLE:
- Grant S if s_req && (!p_req || starve_cnt == STARVE_MAX).
- Otherwise grant P if p_req.
- Otherwise remain in IDLE.
- On any grant, at the same edge:
  - latch owner;
  - load mem_addr, mem_we, mem_wdata from the granted port;
  - set mem_en = 1;
  - set cnt = MEM_LAT;
  - go to WAIT.
- starve_cnt:
  - increments (saturating at STARVE_MAX) on a P grant while s_req = 1;
  - clears on an S grant.

WAIT:
- mem_en is 1 only in the first WAIT cycle; mem_we is cleared with it.
- cnt decrements each cycle.
- At the edge where cnt == 1:
  - capture mem_rdata into p_rdata (owner P) or s_rdata (owner S), reads only; writes leave both unchanged;
  - go to DONE.

DONE:
- Lasts one cycle; s_ack = 1 in this cycle iff owner = S.
- Always returns to IDLE. There is one guaranteed IDLE cycle between accesses, with no back-to-back grant.

p_stall:
- p_stall = p_req && !(state == DONE && owner == P).
- Latency: p_req rising at cycle T with an idle arbiter gives p_stall high in T..T+MEM_LAT and low in T+MEM_LAT+1. The pipeline advances at the end of that cycle.
- While S owns the memory, p_stall stays high for its full duration.

Boundary cases:
- p_req drops mid-access (flush): the access completes and the write is still committed. Read data is still captured into p_rdata; no stall is asserted without p_req.
- s_req drops before s_ack: protocol violation. The access still completes and s_ack still pulses.
- p_req and s_req both rise in the same IDLE cycle with starve_cnt < STARVE_MAX: P wins.
- starve_cnt == STARVE_MAX: S wins regardless of p_req.
- Reset mid-WAIT: the in-flight access is abandoned and no capture or ack occurs. A write is committed only if its mem_en cycle already elapsed.
- Request inputs must be stable from request until grant; they are sampled only at the grant edge.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all outputs 0 immediately, no clock edge required; p_req = 1 with reset released -> p_stall = 1.
- P read, MEM_LAT = 2, mem at 0x10 = 0xDEADBEEF, p_req at cycle 0 -> mem_en only in cycle 1, p_stall = 1 in cycles 0–2 and 0 in cycle 3, p_rdata = 0xDEADBEEF in cycle 3.
- P write of 0x12345678 to 0x20, then S read of 0x20 -> mem_en/mem_we high for exactly one cycle; s_ack pulses once; s_rdata = 0x12345678; p_rdata unchanged.
- Simultaneous p_req and s_req at cycle 0, p_req held continuously, STARVE_MAX = 4 -> four P grants, then S granted on the fifth; starve_cnt reads 0 after the S grant.
- S owns memory while p_req rises mid-WAIT -> p_stall stays high through S's DONE and the following P access; P completes MEM_LAT+2 cycles after S's DONE.
- rst_n asserted during WAIT of an S read -> s_ack never pulses, state = IDLE, s_rdata = 0; the next S request completes normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Signal bundle joining the data-memory arbiter to the MEM stage, the syscall
// handler and the single-port data memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;
  logic              p_stall;

  logic              s_req;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_ack;
  logic [DATA_W-1:0] s_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_rdata, p_stall,
    input  s_req, s_we, s_addr, s_wdata,
    output s_ack, s_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_rdata, p_stall,
    output s_req, s_we, s_addr, s_wdata,
    input  s_ack, s_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (P) and the syscall
// handler (S); fixed memory latency becomes a stall toward P and an ack toward S.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);
  localparam logic [SC_W-1:0]  STARVE_TOP = SC_W'(STARVE_MAX);
  localparam logic [SC_W-1:0]  STARVE_ONE = SC_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic {OWN_P = 1'b0, OWN_S = 1'b1} owner_t;

  state_t            state, state_nxt;
  owner_t            owner;
  logic [CNT_W-1:0]  cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              grant_p, grant_s;
  logic              op_we;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] p_rdata_q, s_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // S only overtakes a pending P once P has been granted STARVE_MAX times in a row.
  always_comb begin
    state_nxt = state;
    grant_p   = 1'b0;
    grant_s   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.s_req && (!bus.p_req || starve_cnt == STARVE_TOP)) begin
          grant_s   = 1'b1;
          state_nxt = WAIT;
        end else if (bus.p_req) begin
          grant_p   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= OWN_P;
      cnt         <= '0;
      starve_cnt  <= '0;
      op_we       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p_rdata_q   <= '0;
      s_rdata_q   <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if (grant_p || grant_s) begin
        owner       <= grant_s ? OWN_S : OWN_P;
        op_we       <= grant_s ? bus.s_we : bus.p_we;
        mem_en_q    <= 1'b1;
        mem_we_q    <= grant_s ? bus.s_we : bus.p_we;
        mem_addr_q  <= grant_s ? bus.s_addr : bus.p_addr;
        mem_wdata_q <= grant_s ? bus.s_wdata : bus.p_wdata;
        cnt         <= CNT_INIT;
      end
      if (grant_s)
        starve_cnt <= '0;
      else if (grant_p && bus.s_req && starve_cnt != STARVE_TOP)
        starve_cnt <= starve_cnt + STARVE_ONE;
      // op_we rather than mem_we_q: the strobe is gone by the last WAIT cycle.
      if (state == WAIT) begin
        cnt <= cnt - CNT_LAST;
        if (cnt == CNT_LAST && !op_we) begin
          if (owner == OWN_P) p_rdata_q <= bus.mem_rdata;
          else                s_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.p_stall   = bus.p_req && !(state == DONE && owner == OWN_P);
  assign bus.s_ack     = (state == DONE) && (owner == OWN_S);
  assign bus.p_rdata   = p_rdata_q;
  assign bus.s_rdata   = s_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: synchronous-read memory model, expected read
// data queued at request time and compared when the arbiter completes.
module tb_dmem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, so data appears the cycle after mem_en (MEM_LAT = 2).
  logic [31:0] mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  int en_cnt = 0, we_cnt = 0, ack_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_en)               en_cnt  <= en_cnt + 1;
    if (bus.mem_en && bus.mem_we) we_cnt  <= we_cnt + 1;
    if (bus.s_ack)                ack_cnt <= ack_cnt + 1;
  end

  logic [31:0] pq[$];
  logic [31:0] sq[$];

  function automatic logic [31:0] pop_p();
    if (pq.size() > 0) return pq.pop_front();
    return 'x;
  endfunction

  function automatic logic [31:0] pop_s();
    if (sq.size() > 0) return sq.pop_front();
    return 'x;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Called #1 after a posedge with the arbiter idle; returns #1 after the posedge following DONE.
  task automatic p_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input string tag);
    int n;
    bus.p_req = 1'b1; bus.p_we = we; bus.p_addr = a; bus.p_wdata = d;
    if (!we) pq.push_back(exp);
    n = 0;
    @(negedge clk);
    while (bus.p_stall === 1'b1 && n < 40) begin @(negedge clk); n++; end
    check({tag, "_lat"}, n, MEM_LAT + 1);
    if (!we) check({tag, "_rdata"}, bus.p_rdata, pop_p());
    @(posedge clk); #1;
    bus.p_req = 1'b0;
  endtask

  task automatic s_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input string tag);
    int n;
    bus.s_req = 1'b1; bus.s_we = we; bus.s_addr = a; bus.s_wdata = d;
    if (!we) sq.push_back(exp);
    n = 0;
    @(negedge clk);
    while (bus.s_ack !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check({tag, "_lat"}, n, MEM_LAT + 1);
    if (!we) check({tag, "_rdata"}, bus.s_rdata, pop_s());
    @(posedge clk); #1;
    bus.s_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pcnt, en0, we0, ack0;
    logic stall_ok;
    rst_n = 1'b1;
    bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.s_req = 1'b0; bus.s_we = 1'b0; bus.s_addr = '0; bus.s_wdata = '0;

    // Asynchronous reset mid-cycle, before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_en",    bus.mem_en, 0);
    check("rst_mem_we",    bus.mem_we, 0);
    check("rst_mem_addr",  bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_p_rdata",   bus.p_rdata, 0);
    check("rst_s_rdata",   bus.s_rdata, 0);
    check("rst_s_ack",     bus.s_ack, 0);
    check("rst_p_stall",   bus.p_stall, 0);

    preload(8'h10, 32'hDEADBEEF);
    preload(8'h30, 32'hA5A5_0030);
    preload(8'h40, 32'hB4B4_0040);
    @(negedge clk);
    rst_n = 1'b1;
    #1 bus.p_req = 1'b1;
    #1 check("idle_p_stall", bus.p_stall, 1);
    bus.p_req = 1'b0;

    // P read cycle by cycle
    @(posedge clk); #1;
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h10;
    pq.push_back(32'hDEADBEEF);
    @(negedge clk); check("rd_c0_stall", bus.p_stall, 1); check("rd_c0_en", bus.mem_en, 0);
    @(negedge clk); check("rd_c1_stall", bus.p_stall, 1); check("rd_c1_en", bus.mem_en, 1);
    @(negedge clk); check("rd_c2_stall", bus.p_stall, 1); check("rd_c2_en", bus.mem_en, 0);
    @(negedge clk); check("rd_c3_stall", bus.p_stall, 0); check("rd_c3_rdata", bus.p_rdata, pop_p());
    @(posedge clk); #1;
    bus.p_req = 1'b0;

    // P write then S read of the same word
    en0 = en_cnt; we0 = we_cnt;
    p_access(1'b1, 32'h20, 32'h12345678, 32'h0, "pwr");
    check("pwr_en_cycles", en_cnt - en0, 1);
    check("pwr_we_cycles", we_cnt - we0, 1);
    ack0 = ack_cnt;
    s_access(1'b0, 32'h20, 32'h0, 32'h12345678, "srd");
    check("srd_ack_pulses", ack_cnt - ack0, 1);
    check("srd_p_rdata_kept", bus.p_rdata, 32'hDEADBEEF);

    // Starvation: P held continuously alongside S
    @(posedge clk); #1;
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h30;
    bus.s_req = 1'b1; bus.s_we = 1'b0; bus.s_addr = 32'h40;
    for (int i = 0; i < STARVE_MAX + 1; i++) pq.push_back(32'hA5A5_0030);
    sq.push_back(32'hB4B4_0040);
    pcnt = 0; n = 0;
    @(negedge clk);
    while (bus.s_ack !== 1'b1 && n < 60) begin
      if (bus.p_stall === 1'b0) begin
        pcnt++;
        check("starve_p_rdata", bus.p_rdata, pop_p());
      end
      @(negedge clk); n++;
    end
    check("starve_p_grants", pcnt, STARVE_MAX);
    check("starve_cnt_clr", dut.starve_cnt, 0);
    check("starve_s_rdata", bus.s_rdata, pop_s());
    check("starve_stall_in_s", bus.p_stall, 1);
    @(posedge clk); #1;
    bus.s_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.p_stall === 1'b1 && n < 20);
    check("starve_p_after_s_lat", n, MEM_LAT + 2);
    check("starve_p_after_s_rdata", bus.p_rdata, pop_p());
    @(posedge clk); #1;
    bus.p_req = 1'b0;

    // S write owns memory, P arrives mid-WAIT
    @(posedge clk); #1;
    bus.s_req = 1'b1; bus.s_we = 1'b1; bus.s_addr = 32'h50; bus.s_wdata = 32'h0000_55AA;
    @(posedge clk); #1;
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h10;
    pq.push_back(32'hDEADBEEF);
    stall_ok = 1'b1; n = 0;
    @(negedge clk);
    while (bus.s_ack !== 1'b1 && n < 20) begin
      stall_ok = stall_ok & (bus.p_stall === 1'b1);
      @(negedge clk); n++;
    end
    check("sown_stall_wait", stall_ok, 1);
    check("sown_stall_done", bus.p_stall, 1);
    check("sown_s_rdata_kept", bus.s_rdata, 32'hB4B4_0040);
    @(posedge clk); #1;
    bus.s_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.p_stall === 1'b1 && n < 20);
    check("sown_p_lat", n, MEM_LAT + 2);
    check("sown_p_rdata", bus.p_rdata, pop_p());
    @(posedge clk); #1;
    bus.p_req = 1'b0;
    s_access(1'b0, 32'h50, 32'h0, 32'h0000_55AA, "sown_rb");

    // Flush: P write request drops after the grant, write still lands
    @(posedge clk); #1;
    bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = 32'h60; bus.p_wdata = 32'hC0FFEE01;
    @(negedge clk); check("flush_c0_stall", bus.p_stall, 1);
    @(posedge clk); #1;
    bus.p_req = 1'b0;
    @(negedge clk);
    check("flush_c1_stall", bus.p_stall, 0);
    check("flush_c1_wr", {bus.mem_en, bus.mem_we}, 2'b11);
    repeat (3) @(posedge clk);
    #1;
    s_access(1'b0, 32'h60, 32'h0, 32'hC0FFEE01, "flush_rb");

    // Reset during WAIT of an S read
    @(posedge clk); #1;
    bus.s_req = 1'b1; bus.s_we = 1'b0; bus.s_addr = 32'h10;
    @(negedge clk);
    @(negedge clk); check("rstw_c1_en", bus.mem_en, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.s_req = 1'b0;
    #1;
    check("rstw_s_ack", bus.s_ack, 0);
    check("rstw_s_rdata", bus.s_rdata, 0);
    check("rstw_state", dut.state, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ack0 = ack_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("rstw_no_ack", ack_cnt - ack0, 0);
    s_access(1'b0, 32'h60, 32'h0, 32'hC0FFEE01, "rstw_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
